// File: rtl/page_table_walker_if.sv
// Purpose: request, memory-read and TLB-update bundle for the Sv32 page-table walker.
// Latency: none, wiring only.
// Backpressure: valid/ready on the request and memory-request channels; responses and updates cannot be stalled.
//
// Ports (slave = walker side, master = requester/memory side):
//   req_valid/req_ready/req_vaddr/req_is_store : walk request for a missed virtual address
//   satp_ppn                                   : root page-table PPN
//   abort                                      : flush/sfence, cancels the walk in progress
//   mem_req_valid/mem_req_ready/mem_req_addr   : PTE read request
//   mem_resp_valid/mem_resp_data               : PTE read data, at most one read outstanding
//   update_valid/update_vpn/update_ppn/update_pte/update_level : TLB write port
//   walk_done/walk_fault                       : completion pulse and its fault qualifier
interface page_table_walker_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_vaddr;
  logic            req_is_store;
  logic [21:0]     satp_ppn;
  logic            abort;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [31:0]     mem_req_addr;
  logic            mem_resp_valid;
  logic [31:0]     mem_resp_data;
  logic            update_valid;
  logic [31:0]     update_vpn;
  logic [31:0]     update_ppn;
  logic [7:0]      update_pte;
  logic [31:0]     update_level;
  logic            walk_done;
  logic            walk_fault;

  modport slave (
    input  req_valid, req_vaddr, req_is_store, satp_ppn, abort,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, mem_req_valid, mem_req_addr,
    output update_valid, update_vpn, update_ppn, update_pte, update_level,
    output walk_done, walk_fault
  );

  modport master (
    output req_valid, req_vaddr, req_is_store, satp_ppn, abort,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, mem_req_valid, mem_req_addr,
    input  update_valid, update_vpn, update_ppn, update_pte, update_level,
    input  walk_done, walk_fault
  );
endinterface

// File: rtl/page_table_walker.sv
// Purpose: Sv32 page-table walker; reads up to two PTEs and writes one leaf mapping into the TLB or reports a page fault.
// Latency: with zero-wait memory, done 3 cycles after acceptance for a 4 MB superpage, 5 cycles for a 4 KB page.
// Backpressure: accepts only in IDLE; holds mem_req_valid/mem_req_addr stable until mem_req_ready; abort cancels at any point.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : page_table_walker_if.slave (request, PTE memory read, TLB update, completion)
module page_table_walker #(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  page_table_walker_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L0_REQ  = 3'd3,
    L0_WAIT = 3'd4,
    UPDATE  = 3'd5,
    FAULT   = 3'd6,
    DRAIN   = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [19:0] r_vpn;
  logic        r_is_store;
  logic [31:0] r_mem_req_addr;
  logic [31:0] r_update_vpn;
  logic [31:0] r_update_ppn;
  logic [7:0]  r_update_pte;
  logic [31:0] r_update_level;
  logic        r_walk_fault;

  // PTE field decode of the incoming response.
  logic [31:0] w_pte;
  logic        w_pte_v;
  logic        w_pte_r;
  logic        w_pte_w;
  logic        w_pte_x;
  logic        w_pte_a;
  logic        w_pte_d;
  logic        w_leaf;
  logic        w_common_fault;
  logic        w_l1_misaligned;
  logic        w_unused_bits;

  assign w_pte   = bus.mem_resp_data;
  assign w_pte_v = w_pte[0];
  assign w_pte_r = w_pte[1];
  assign w_pte_w = w_pte[2];
  assign w_pte_x = w_pte[3];
  assign w_pte_a = w_pte[6];
  assign w_pte_d = w_pte[7];
  assign w_leaf  = w_pte_r | w_pte_x;

  // Faults common to both levels, highest priority first. A/D are
  // software-managed, so a clear A (or clear D on a store) is a fault
  // rather than a PTE write-back.
  assign w_common_fault = !w_pte_v
                        || (!w_pte_r && w_pte_w)
                        || (w_leaf && !w_pte_a)
                        || (w_leaf && r_is_store && !w_pte_d);

  // A superpage must have PPN[0] == 0.
  assign w_l1_misaligned = (w_pte[19:10] != 10'd0);

  // Page offset, the top satp bits (32-bit physical space) and the RSW
  // bits never influence the walk.
  assign w_unused_bits = ^{bus.req_vaddr[11:0], bus.satp_ppn[21:20], w_pte[9:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Abort is evaluated before every other condition in each state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) w_next_state = L1_REQ;
      end
      L1_REQ, L0_REQ: begin
        if (bus.abort) begin
          // A handshake in the abort cycle means a read is in flight.
          w_next_state = bus.mem_req_ready ? DRAIN : IDLE;
        end else if (bus.mem_req_ready) begin
          w_next_state = (r_state == L1_REQ) ? L1_WAIT : L0_WAIT;
        end
      end
      L1_WAIT: begin
        if (bus.abort) begin
          w_next_state = bus.mem_resp_valid ? IDLE : DRAIN;
        end else if (bus.mem_resp_valid) begin
          if (w_common_fault || (w_leaf && w_l1_misaligned)) w_next_state = FAULT;
          else if (w_leaf)                                   w_next_state = UPDATE;
          else                                               w_next_state = L0_REQ;
        end
      end
      L0_WAIT: begin
        if (bus.abort) begin
          w_next_state = bus.mem_resp_valid ? IDLE : DRAIN;
        end else if (bus.mem_resp_valid) begin
          // No third level in Sv32: a pointer at level 0 is a fault.
          if (w_common_fault || !w_leaf) w_next_state = FAULT;
          else                           w_next_state = UPDATE;
        end
      end
      UPDATE, FAULT: begin
        w_next_state = IDLE;
      end
      DRAIN: begin
        if (bus.mem_resp_valid) w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vpn          <= 20'd0;
      r_is_store     <= 1'b0;
      r_mem_req_addr <= 32'd0;
      r_update_vpn   <= 32'd0;
      r_update_ppn   <= 32'd0;
      r_update_pte   <= 8'd0;
      r_update_level <= 32'd0;
      r_walk_fault   <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.req_valid) begin
        r_vpn          <= bus.req_vaddr[XLEN-1:12];
        r_is_store     <= bus.req_is_store;
        // Root address is formed at acceptance so mem_req_addr is a
        // register output; satp is static for the duration of a walk.
        r_mem_req_addr <= {bus.satp_ppn[19:0], bus.req_vaddr[31:22], 2'b00};
      end
      if (r_state == L1_WAIT && w_next_state == L0_REQ) begin
        r_mem_req_addr <= {w_pte[29:10], r_vpn[9:0], 2'b00};
      end
      if (w_next_state == UPDATE) begin
        r_update_vpn   <= {12'd0, r_vpn};
        r_update_ppn   <= {10'd0, w_pte[31:10]};
        r_update_pte   <= w_pte[7:0];
        r_update_level <= (r_state == L1_WAIT) ? 32'd1 : 32'd0;
        r_walk_fault   <= 1'b0;
      end
      if (w_next_state == FAULT) begin
        r_walk_fault   <= 1'b1;
      end
    end
  end

  assign bus.req_ready     = (r_state == IDLE);
  assign bus.mem_req_valid = (r_state == L1_REQ) || (r_state == L0_REQ);
  assign bus.mem_req_addr  = r_mem_req_addr;
  // An abort landing on the completion cycle swallows the pulse.
  assign bus.update_valid  = (r_state == UPDATE) && !bus.abort;
  assign bus.walk_done     = ((r_state == UPDATE) || (r_state == FAULT)) && !bus.abort;
  assign bus.walk_fault    = r_walk_fault;
  assign bus.update_vpn    = r_update_vpn;
  assign bus.update_ppn    = r_update_ppn;
  assign bus.update_pte    = r_update_pte;
  assign bus.update_level  = r_update_level;

endmodule

// File: tb/tb_page_table_walker.sv
// Purpose: directed self-checking bench for page_table_walker.
// Latency: n/a.
// Backpressure: drives mem_req_ready stalls and abort/reset mid-walk.
module tb_page_table_walker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  page_table_walker_if #(.XLEN(32)) bus ();

  page_table_walker #(.XLEN(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Walk results collected by do_walk.
  int          w_reads;
  int          w_lat;
  int          w_addr_moves;
  logic [31:0] w_addr1;
  logic [31:0] w_addr2;
  logic        w_done;
  logic        w_upd;
  logic        w_fault;
  logic [31:0] w_vpn;
  logic [31:0] w_ppn;
  logic [31:0] w_level;
  logic [7:0]  w_pte;
  logic        w_rdy_pulse;
  logic        w_rdy_after;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and plays a memory that answers the cycle after each
  // handshake, optionally withholding mem_req_ready for 'stall' cycles.
  task automatic do_walk(input logic [31:0] vaddr, input logic [21:0] satp, input logic st,
                         input logic [31:0] pte1, input logic [31:0] pte2, input int stall);
    int          stall_left;
    logic        resp_next;
    logic        have_addr;
    logic [31:0] held_addr;
    stall_left = stall;
    resp_next = 1'b0;
    have_addr = 1'b0;
    held_addr = 32'd0;
    w_reads = 0; w_lat = 0; w_addr_moves = 0; w_addr1 = 32'd0; w_addr2 = 32'd0;
    w_done = 1'b0; w_upd = 1'b0; w_fault = 1'b0; w_rdy_pulse = 1'b1; w_rdy_after = 1'b0;
    w_vpn = 32'd0; w_ppn = 32'd0; w_level = 32'd0; w_pte = 8'd0;
    bus.req_vaddr = vaddr;
    bus.satp_ppn = satp;
    bus.req_is_store = st;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.req_vaddr = 32'd0;
    for (int c = 1; c <= 60 && !w_done; c++) begin
      bus.mem_resp_valid = resp_next;
      bus.mem_resp_data = resp_next ? ((w_reads == 1) ? pte1 : pte2) : 32'd0;
      resp_next = 1'b0;
      bus.mem_req_ready = 1'b0;
      if (bus.update_valid) begin
        w_upd = 1'b1;
        w_vpn = bus.update_vpn;
        w_ppn = bus.update_ppn;
        w_level = bus.update_level;
        w_pte = bus.update_pte;
      end
      if (bus.walk_done) begin
        w_done = 1'b1;
        w_fault = bus.walk_fault;
        w_lat = c;
        w_rdy_pulse = bus.req_ready;
      end else if (bus.mem_req_valid) begin
        if (!have_addr) begin
          held_addr = bus.mem_req_addr;
          have_addr = 1'b1;
        end else if (bus.mem_req_addr != held_addr) begin
          w_addr_moves++;
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          bus.mem_req_ready = 1'b1;
          w_reads++;
          if (w_reads == 1) w_addr1 = bus.mem_req_addr;
          else              w_addr2 = bus.mem_req_addr;
          resp_next = 1'b1;
          have_addr = 1'b0;
        end
      end
      if (!w_done) tick();
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = 32'd0;
    if (w_done) begin
      tick();
      w_rdy_after = bus.req_ready;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_done;
    logic seen_upd;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_vaddr = 32'd0;
    bus.req_is_store = 1'b0;
    bus.satp_ppn = 22'd0;
    bus.abort = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_update_valid", 32'(bus.update_valid), 32'd0);
    check("rst_walk_done", 32'(bus.walk_done), 32'd0);
    check("rst_walk_fault", 32'(bus.walk_fault), 32'd0);
    check("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
    check("rst_update_vpn", bus.update_vpn, 32'd0);
    reset = 1'b0;
    tick();

    // Superpage hit.
    do_walk(32'h4012_3456, 22'h00080, 1'b0, 32'h0000_00CF, 32'd0, 0);
    check("sp_done", 32'(w_done), 32'd1);
    check("sp_reads", 32'(w_reads), 32'd1);
    check("sp_addr", w_addr1, 32'h0008_0400);
    check("sp_fault", 32'(w_fault), 32'd0);
    check("sp_update", 32'(w_upd), 32'd1);
    check("sp_vpn", w_vpn, 32'h0004_0123);
    check("sp_ppn", w_ppn, 32'h0000_0000);
    check("sp_pte", 32'(w_pte), 32'h0000_00CF);
    check("sp_level", w_level, 32'd1);
    check("sp_latency", 32'(w_lat), 32'd3);
    check("sp_rdy_in_pulse", 32'(w_rdy_pulse), 32'd0);
    check("sp_rdy_after", 32'(w_rdy_after), 32'd1);

    // Two-level 4 KB page.
    do_walk(32'h0040_3ABC, 22'h00080, 1'b0, 32'h0002_0001, 32'h1234_50D7, 0);
    check("4k_reads", 32'(w_reads), 32'd2);
    check("4k_addr1", w_addr1, 32'h0008_0004);
    check("4k_addr2", w_addr2, 32'h0008_000C);
    check("4k_fault", 32'(w_fault), 32'd0);
    check("4k_update", 32'(w_upd), 32'd1);
    check("4k_vpn", w_vpn, 32'h0000_0403);
    check("4k_ppn", w_ppn, 32'h0004_8D14);
    check("4k_pte", 32'(w_pte), 32'h0000_00D7);
    check("4k_level", w_level, 32'd0);
    check("4k_latency", 32'(w_lat), 32'd5);

    // V=0 at level 1.
    do_walk(32'h4012_3456, 22'h00080, 1'b0, 32'h0000_0000, 32'd0, 0);
    check("inv_done", 32'(w_done), 32'd1);
    check("inv_fault", 32'(w_fault), 32'd1);
    check("inv_update", 32'(w_upd), 32'd0);

    // Misaligned superpage.
    do_walk(32'h4012_3456, 22'h00080, 1'b0, 32'h0000_04CF, 32'd0, 0);
    check("mis_fault", 32'(w_fault), 32'd1);
    check("mis_update", 32'(w_upd), 32'd0);

    // D=0 leaf: store faults, load succeeds.
    do_walk(32'h4012_3456, 22'h00080, 1'b1, 32'h0000_004F, 32'd0, 0);
    check("dst_fault", 32'(w_fault), 32'd1);
    check("dst_update", 32'(w_upd), 32'd0);
    do_walk(32'h4012_3456, 22'h00080, 1'b0, 32'h0000_004F, 32'd0, 0);
    check("dld_fault", 32'(w_fault), 32'd0);
    check("dld_update", 32'(w_upd), 32'd1);
    check("dld_pte", 32'(w_pte), 32'h0000_004F);

    // Backpressure: ready withheld for 4 cycles.
    do_walk(32'h4012_3456, 22'h00080, 1'b0, 32'h0000_00CF, 32'd0, 4);
    check("bp_reads", 32'(w_reads), 32'd1);
    check("bp_addr_moves", 32'(w_addr_moves), 32'd0);
    check("bp_addr", w_addr1, 32'h0008_0400);
    check("bp_latency", 32'(w_lat), 32'd7);
    check("bp_update", 32'(w_upd), 32'd1);

    // Level-0 non-leaf faults.
    do_walk(32'h0040_3ABC, 22'h00080, 1'b0, 32'h0002_0001, 32'h0000_0001, 0);
    check("l0nl_reads", 32'(w_reads), 32'd2);
    check("l0nl_fault", 32'(w_fault), 32'd1);
    check("l0nl_update", 32'(w_upd), 32'd0);

    // Abort in L1_WAIT, response 3 cycles later.
    bus.req_vaddr = 32'h4012_3456;
    bus.satp_ppn = 22'h00080;
    bus.req_is_store = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    seen_done = 1'b0;
    seen_upd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen_done |= bus.walk_done;
      seen_upd |= bus.update_valid;
      check("ab_rdy_low", 32'(bus.req_ready), 32'd0);
      if (i == 2) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = 32'h0000_00CF;
      end
      tick();
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = 32'd0;
    seen_done |= bus.walk_done;
    seen_upd |= bus.update_valid;
    check("ab_rdy_back", 32'(bus.req_ready), 32'd1);
    check("ab_no_done", 32'(seen_done), 32'd0);
    check("ab_no_update", 32'(seen_upd), 32'd0);

    // Reset during L0_WAIT.
    bus.req_vaddr = 32'h0040_3ABC;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = 32'h0002_0001;
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = 32'd0;
    check("rs_l0_addr", bus.mem_req_addr, 32'h0008_000C);
    check("rs_l0_valid", 32'(bus.mem_req_valid), 32'd1);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    check("rs_in_wait", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("rs_req_ready", 32'(bus.req_ready), 32'd1);
    check("rs_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rs_mem_req_addr", bus.mem_req_addr, 32'd0);
    check("rs_update_vpn", bus.update_vpn, 32'd0);
    check("rs_update_level", bus.update_level, 32'd0);
    check("rs_walk_fault", 32'(bus.walk_fault), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = 32'h0000_00CF;
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = 32'd0;
    check("rs_late_done", 32'(bus.walk_done), 32'd0);
    check("rs_late_update", 32'(bus.update_valid), 32'd0);
    check("rs_late_mreq", 32'(bus.mem_req_valid), 32'd0);
    check("rs_late_rdy", 32'(bus.req_ready), 32'd1);

    do_walk(32'h4012_3456, 22'h00080, 1'b0, 32'h0000_00CF, 32'd0, 0);
    check("rs_new_update", 32'(w_upd), 32'd1);
    check("rs_new_vpn", w_vpn, 32'h0004_0123);
    check("rs_new_latency", 32'(w_lat), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
